opll_write_sched: RTL and testbench

Register-write scheduler in front of the VM2413 `opll` core. It accepts CPU register writes (register index plus data) through a valid/ready handshake and buffers them in a small FIFO. It then replays each write on the `opll` bus pins as an address strobe followed by a data strobe, and enforces the YM2413 minimum wait times between strobes, counted in `clkena` (xena) cycles. It sits between the SMS I/O decode (ports F0h/F1h) and `opll`, and shares its `clk`/`clkena`.

---
 rtl/opll_write_sched.sv | 244 ++++++++++++++++++++++++
 tb/tb_opll_write_sched.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opll_write_sched.sv
// ---------------------------------------------------------------------------
// opll_write_sched
//
// Register-write scheduler in front of the VM2413 opll core. CPU writes
// (register index + data) are accepted via a valid/ready handshake into a
// small FIFO. Each entry is replayed on the opll bus as an address strobe
// followed by a data strobe. The YM2413 minimum waits between strobes are
// enforced, counted in clkena (xena) cycles.
//
// Optional feature macro: OPLL_WSCHED_SHADOW_EN
//   Adds a 64x8 shadow copy of the OPLL registers 0x00..0x3F. It is readable
//   through shadow_addr/shadow_data.
//
// Parameters:
//   DEPTH      FIFO entries (power of 2, >= 2)
//   ADDR_WAIT  clkena cycles from the address strobe to the data strobe
//   DATA_WAIT  clkena cycles from the data strobe to the next address strobe
//
// Ports:
//   clk, reset     core clock (opll xin), async active-high reset
//   clkena         opll sample enable (xena)
//   req_valid/req_ready/req_reg/req_data   write request handshake
//   opll_d, opll_a, opll_cs_n, opll_we_n   registered opll bus pins
//   busy           FIFO non-empty or a write is in progress
//   level          FIFO occupancy
//   shadow_addr/shadow_data  (macro only) combinational shadow read port
// ---------------------------------------------------------------------------
module opll_write_sched #(
  parameter int DEPTH     = 4,
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clkena,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [7:0]               req_reg,
  input  logic [7:0]               req_data,
  output logic [7:0]               opll_d,
  output logic                     opll_a,
  output logic                     opll_cs_n,
  output logic                     opll_we_n,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
`ifdef OPLL_WSCHED_SHADOW_EN
  ,
  input  logic [5:0]               shadow_addr,
  output logic [7:0]               shadow_data
`endif
);

  localparam int AW   = $clog2(DEPTH);
  localparam int WMAX = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int CW   = (WMAX < 2) ? 1 : $clog2(WMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_AWAIT,
    S_DATA,
    S_DWAIT
  } state_t;

  // FIFO storage and pointers; the extra pointer bit separates full from empty
  logic [15:0]   mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [15:0]   head;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [7:0]    cur_reg;
  logic [7:0]    cur_data;

  logic          cs_n_nx;
  logic          a_nx;
  logic [7:0]    d_nx;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  // Ready depends only on the registered pointers, so a pop on the same edge
  // never makes room for a push into a full FIFO.
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign level     = wr_ptr - rd_ptr;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign busy      = !empty || (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {req_reg, req_data};
  end

  always_ff @(posedge clk) begin
    if (pop) {cur_reg, cur_data} <= head;
  end

  // Control state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pop      = 1'b0;
    case (state)
      S_IDLE: begin
        // Pop is not gated by clkena: the strobe only has to be stable
        // by the next sampling edge.
        if (!empty) begin
          pop      = 1'b1;
          state_nx = S_ADDR;
        end
      end
      S_ADDR: begin
        if (clkena) begin
          if (ADDR_WAIT == 0) begin
            state_nx = S_DATA;
          end else begin
            cnt_nx   = CW'(ADDR_WAIT);
            state_nx = S_AWAIT;
          end
        end
      end
      S_AWAIT: begin
        if (clkena) begin
          cnt_nx = cnt - 1'b1;
          if (cnt == CW'(1)) state_nx = S_DATA;
        end
      end
      S_DATA: begin
        if (clkena) begin
          if (DATA_WAIT == 0) begin
            if (!empty) begin
              pop      = 1'b1;
              state_nx = S_ADDR;
            end else begin
              state_nx = S_IDLE;
            end
          end else begin
            cnt_nx   = CW'(DATA_WAIT);
            state_nx = S_DWAIT;
          end
        end
      end
      S_DWAIT: begin
        if (clkena) begin
          cnt_nx = cnt - 1'b1;
          if (cnt == CW'(1)) begin
            // Chain straight into the next write when one is queued
            if (!empty) begin
              pop      = 1'b1;
              state_nx = S_ADDR;
            end else begin
              state_nx = S_IDLE;
            end
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // Bus pins are registered from the next state, so a strobe is visible
    // in the same cycle the FSM enters ADDR or DATA.
    cs_n_nx = !((state_nx == S_ADDR) || (state_nx == S_DATA));
    a_nx    = opll_a;
    d_nx    = opll_d;
    if (pop) begin
      // cur_reg is loaded on this same edge, so take the index from the head
      a_nx = 1'b0;
      d_nx = head[15:8];
    end else begin
      case (state_nx)
        S_ADDR, S_AWAIT: begin
          a_nx = 1'b0;
          d_nx = cur_reg;
        end
        S_DATA, S_DWAIT: begin
          a_nx = 1'b1;
          d_nx = cur_data;
        end
        default: ;
      endcase
    end
  end

  // Registered opll bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opll_cs_n <= 1'b1;
      opll_we_n <= 1'b1;
      opll_a    <= 1'b0;
      opll_d    <= 8'h00;
    end else begin
      opll_cs_n <= cs_n_nx;
      opll_we_n <= cs_n_nx;
      opll_a    <= a_nx;
      opll_d    <= d_nx;
    end
  end

`ifdef OPLL_WSCHED_SHADOW_EN
  // Shadow copy of the registers 0x00..0x3F. An entry is committed on the
  // clkena edge where opll samples the data strobe.
  logic [7:0] shadow [64];
  logic       shadow_we;

  assign shadow_we = (state == S_DATA) && clkena && (cur_reg < 8'h40);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) shadow[i] <= 8'h00;
    end else if (shadow_we) begin
      shadow[cur_reg[5:0]] <= cur_data;
    end
  end

  assign shadow_data = shadow[shadow_addr];
`endif

endmodule

// File: tb/tb_opll_write_sched.sv
// ---------------------------------------------------------------------------
// tb_opll_write_sched
//
// Self-checking bench for opll_write_sched. The reference model predicts
// the bus timeline for each write directly from the wait rules. It finds
// the pop edge, the next clkena edge, and the N-th clkena edge after it,
// then paints the expected pin values over those cycle windows. A table of
// hand-derived strobe timings and a few directed sequences cover the corner
// cases.
// ---------------------------------------------------------------------------
module tb_opll_write_sched;
  localparam int DEPTH     = 4;
  localparam int ADDR_WAIT = 12;
  localparam int DATA_WAIT = 84;
  localparam int NMAX      = 6000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clkena = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_reg = 8'h00;
  logic [7:0] req_data = 8'h00;
  logic [7:0] opll_d;
  logic       opll_a;
  logic       opll_cs_n;
  logic       opll_we_n;
  logic       busy;
  logic [$clog2(DEPTH):0] level;
`ifdef OPLL_WSCHED_SHADOW_EN
  logic [5:0] shadow_addr = 6'h30;
  logic [7:0] shadow_data;
`endif

  opll_write_sched #(
    .DEPTH(DEPTH), .ADDR_WAIT(ADDR_WAIT), .DATA_WAIT(DATA_WAIT)
  ) dut (
    .clk(clk), .reset(reset), .clkena(clkena),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_reg(req_reg), .req_data(req_data),
    .opll_d(opll_d), .opll_a(opll_a),
    .opll_cs_n(opll_cs_n), .opll_we_n(opll_we_n),
    .busy(busy), .level(level)
`ifdef OPLL_WSCHED_SHADOW_EN
    , .shadow_addr(shadow_addr), .shadow_data(shadow_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {int t; logic [7:0] r; logic [7:0] d;} wr_t;
  typedef struct {int c; int w; logic [7:0] d; bit dat;} strobe_t;
  typedef struct {
    logic [7:0] r; logic [7:0] d; int per; int ph;
    int a_c; int a_w; int d_c; int d_w; int idle;
  } vec_t;

  int         nvec = 0;
  int         nerr = 0;
  bit         ce       [NMAX];
  bit         exp_cs   [NMAX];
  bit         exp_a    [NMAX];
  logic [7:0] exp_d    [NMAX];
  int         exp_lvl  [NMAX];
  bit         exp_busy [NMAX];
  int         lvl_log  [NMAX];
  logic [7:0] sh_log   [NMAX];
  wr_t        src[$];
  wr_t        q[$];
  strobe_t    st[$];
  int         acc_edge[$];
  int         free_edge;
  int         idle_at;
  int         max_lvl;
  bit         seen_data;
  bit         prev_cs;
  bit         prev_a;

  task automatic chk(string nm, int act, int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      if (nerr <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int next_ce(int after);
    for (int e = after + 1; e < NMAX; e++) if (ce[e]) return e;
    return NMAX;
  endfunction

  function automatic int nth_ce(int from, int n);
    int e = from;
    for (int i = 0; i < n; i++) e = next_ce(e);
    return e;
  endfunction

  task automatic paint(int lo, int hi, bit cs, bit a, logic [7:0] d);
    for (int c = lo; c < hi && c < NMAX; c++) begin
      exp_cs[c] = cs; exp_a[c] = a; exp_d[c] = d;
    end
  endtask

  // Timeline of one write popped at edge p
  task automatic schedule(int p, wr_t w);
    int a1, d0, d1;
    a1 = next_ce(p);
    d0 = nth_ce(a1, ADDR_WAIT);
    d1 = next_ce(d0);
    free_edge = nth_ce(d1, DATA_WAIT);
    paint(p,  a1,   1'b0, 1'b0, w.r);
    paint(a1, d0,   1'b1, 1'b0, w.r);
    paint(d0, d1,   1'b0, 1'b1, w.d);
    paint(d1, NMAX, 1'b1, 1'b1, w.d);
  endtask

  task automatic set_ce_periodic(int per, int ph);
    for (int k = 0; k < NMAX; k++) ce[k] = ((k % per) == ph);
  endtask

  task automatic check_cycle(int c);
    string s;
    s = $sformatf("@%0d", c);
    chk({"cs_n", s},  int'(opll_cs_n), int'(exp_cs[c]));
    chk({"we_n", s},  int'(opll_we_n), int'(exp_cs[c]));
    chk({"a", s},     int'(opll_a),    int'(exp_a[c]));
    chk({"d", s},     int'(opll_d),    int'(exp_d[c]));
    chk({"level", s}, int'(level),     exp_lvl[c]);
    chk({"busy", s},  int'(busy),      int'(exp_busy[c]));
    lvl_log[c] = int'(level);
    if (int'(level) > max_lvl) max_lvl = int'(level);
    if (!opll_cs_n) begin
      if (prev_cs || (prev_a != opll_a)) begin
        st.push_back('{c, 1, opll_d, opll_a});
        if (opll_a) seen_data = 1'b1;
      end else begin
        strobe_t t;
        t = st[st.size() - 1];
        t.w++;
        st[st.size() - 1] = t;
      end
    end
    if (seen_data && !busy && idle_at < 0) idle_at = c;
    prev_cs = opll_cs_n;
    prev_a  = opll_a;
`ifdef OPLL_WSCHED_SHADOW_EN
    sh_log[c] = shadow_data;
`else
    sh_log[c] = 8'h00;
`endif
  endtask

  // Async reset between clock edges, then ncyc cycles of src stimulus
  task automatic run(int ncyc);
    int  si;
    bit  rdy, pop, push;
    wr_t w;
    si = 0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_cs_n",  int'(opll_cs_n), 1);
    chk("rst_we_n",  int'(opll_we_n), 1);
    chk("rst_a",     int'(opll_a),    0);
    chk("rst_d",     int'(opll_d),    0);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_busy",  int'(busy),      0);
    chk("rst_level", int'(level),     0);
    req_valid = 1'b0;
    clkena    = 1'b0;
    q.delete(); st.delete(); acc_edge.delete();
    free_edge = 0; idle_at = -1; max_lvl = 0; seen_data = 1'b0;
    prev_cs = 1'b1; prev_a = 1'b0;
    for (int c = 0; c < NMAX; c++) begin
      exp_cs[c] = 1'b1; exp_a[c] = 1'b0; exp_d[c] = 8'h00;
      exp_lvl[c] = 0; exp_busy[c] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) check_cycle(k - 1);
      clkena = ce[k];
      if (si < src.size() && src[si].t <= k) begin
        req_valid = 1'b1; req_reg = src[si].r; req_data = src[si].d;
      end else begin
        req_valid = 1'b0; req_reg = 8'($urandom); req_data = 8'($urandom);
      end
      rdy = (q.size() < DEPTH);
      chk($sformatf("ready@%0d", k), int'(req_ready), int'(rdy));
      pop  = (q.size() > 0) && (k >= free_edge);
      push = req_valid && rdy;
      if (pop) begin
        w = q.pop_front();
        schedule(k, w);
      end
      if (push) begin
        q.push_back(src[si]);
        acc_edge.push_back(k);
        si++;
      end
      exp_lvl[k]  = q.size();
      exp_busy[k] = (q.size() > 0) || (k < free_edge);
      @(posedge clk);
      @(negedge clk);
    end
    check_cycle(ncyc - 1);
  endtask

  initial begin
    vec_t vt [4];
    int   cnt;
    int   n_a;
    int   t;
    bit   ok;

    vt[0] = '{8'h10, 8'h55, 1, 0, 1, 1, 14, 1,  99};
    vt[1] = '{8'h3A, 8'hC3, 2, 0, 1, 1, 26, 2, 196};
    vt[2] = '{8'h07, 8'hFF, 3, 0, 1, 2, 39, 3, 294};
    vt[3] = '{8'h20, 8'h01, 3, 1, 1, 3, 40, 3, 295};

    // Single write under several clkena patterns
    for (int i = 0; i < 4; i++) begin
      src.delete();
      src.push_back('{0, vt[i].r, vt[i].d});
      set_ce_periodic(vt[i].per, vt[i].ph);
      run(vt[i].idle + 10);
      chk($sformatf("v%0d_nstrobes", i), int'(st.size() >= 2), 1);
      if (st.size() >= 2) begin
        chk($sformatf("v%0d_a_cycle", i), st[0].c, vt[i].a_c);
        chk($sformatf("v%0d_a_width", i), st[0].w, vt[i].a_w);
        chk($sformatf("v%0d_a_sel", i),   int'(st[0].dat), 0);
        chk($sformatf("v%0d_a_d", i),     int'(st[0].d), int'(vt[i].r));
        chk($sformatf("v%0d_d_cycle", i), st[1].c, vt[i].d_c);
        chk($sformatf("v%0d_d_width", i), st[1].w, vt[i].d_w);
        chk($sformatf("v%0d_d_sel", i),   int'(st[1].dat), 1);
        chk($sformatf("v%0d_d_d", i),     int'(st[1].d), int'(vt[i].d));
        cnt = 0;
        for (int e = st[0].c + st[0].w; e <= st[1].c; e++) if (ce[e]) cnt++;
        chk($sformatf("v%0d_ce_gap", i), cnt, ADDR_WAIT + 1);
      end
      chk($sformatf("v%0d_idle", i), idle_at, vt[i].idle);
    end

    // Back-to-back: six writes, the sixth blocked on a full FIFO
    src.delete();
    for (int i = 0; i < 6; i++) src.push_back('{i, 8'(8'h20 + i), 8'(8'hA0 + i)});
    set_ce_periodic(1, 0);
    run(600);
    n_a = 0;
    foreach (st[i]) begin
      if (!st[i].dat) begin
        if (n_a < 6) begin
          chk($sformatf("b2b_a%0d_cycle", n_a), st[i].c, 1 + 98 * n_a);
          chk($sformatf("b2b_a%0d_d", n_a), int'(st[i].d), 8'h20 + n_a);
        end
        n_a++;
      end
    end
    chk("b2b_n_addr", n_a, 6);
    chk("b2b_max_level", max_lvl, 4);
    chk("b2b_acc5", int'(acc_edge.size() == 6 ? acc_edge[4] : -1), 4);
    chk("b2b_acc6", int'(acc_edge.size() == 6 ? acc_edge[5] : -1), 100);

    // Simultaneous push and pop with two entries queued
    src.delete();
    src.push_back('{0, 8'h01, 8'h11});
    src.push_back('{1, 8'h02, 8'h22});
    src.push_back('{2, 8'h03, 8'h33});
    src.push_back('{99, 8'h04, 8'h44});
    run(120);
    chk("pp_level98", lvl_log[98], 2);
    chk("pp_level99", lvl_log[99], 2);
    chk("pp_acc", int'(acc_edge.size() == 4 ? acc_edge[3] : -1), 99);

    // Reset during DWAIT with two entries queued, then silence until a new push
    src.delete();
    src.push_back('{0, 8'h41, 8'h51});
    src.push_back('{1, 8'h42, 8'h52});
    src.push_back('{2, 8'h43, 8'h53});
    run(50);
    chk("rd_level_before", lvl_log[49], 2);
    src.delete();
    src.push_back('{200, 8'h06, 8'h09});
    run(260);
    chk("rd_first_strobe", int'(st.size() > 0 ? st[0].c : -1), 201);

`ifdef OPLL_WSCHED_SHADOW_EN
    // Shadow: 0x30 recorded at the data-strobe clkena edge, 0x45 ignored
    shadow_addr = 6'h30;
    src.delete();
    src.push_back('{0, 8'h30, 8'h7F});
    src.push_back('{1, 8'h45, 8'h11});
    run(200);
    chk("sh_30_before", int'(sh_log[14]), 8'h00);
    chk("sh_30_after",  int'(sh_log[15]), 8'h7F);
    chk("sh_30_end",    int'(sh_log[199]), 8'h7F);
    shadow_addr = 6'h05;
    #1;
    chk("sh_05_untouched", int'(shadow_data), 8'h00);
    shadow_addr = 6'h30;
    src.delete();
    run(5);
    chk("sh_reset_clear", int'(sh_log[0]), 8'h00);
`endif

    // Leave a data strobe low so the next reset has to drop it at once
    src.delete();
    src.push_back('{0, 8'h0E, 8'h0F});
    set_ce_periodic(1, 0);
    run(15);

    // Randomized clkena and write arrivals against the timeline model
    for (int k = 0; k < NMAX; k++) ce[k] = ($urandom_range(0, 99) < 60);
    src.delete();
    t = 0;
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) t += $urandom_range(0, 3);
      else t += $urandom_range(50, 250);
      src.push_back('{t, 8'($urandom), 8'($urandom)});
    end
    run(4500);
    for (int i = 0; i < st.size(); i++) begin
      if (st[i].c + st[i].w < 4499) begin
        ok = ce[st[i].c + st[i].w];
        for (int e = st[i].c + 1; e < st[i].c + st[i].w; e++) if (ce[e]) ok = 1'b0;
        chk($sformatf("rnd_strobe_end@%0d", st[i].c), int'(ok), 1);
      end
      if (!st[i].dat && i + 1 < st.size() && st[i + 1].dat) begin
        cnt = 0;
        for (int e = st[i].c + st[i].w; e <= st[i + 1].c; e++) if (ce[e]) cnt++;
        chk($sformatf("rnd_ce_gap@%0d", st[i].c), cnt, ADDR_WAIT + 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
